// File: rtl/conv_pkg.sv
// Shared definitions for the K=7 rate-1/3 tail-biting code and its decoder.
// Provides the trellis constants, the generator taps (octal 133/171/165, MSB = c0),
// the decoder FSM encoding, and helpers for the expected branch symbol and Hamming distance.
package conv_pkg;

  localparam int K       = 7;
  localparam int SW      = K - 1;          // trellis state width
  localparam int NSTATES = 1 << SW;

  // Generator taps over {c0,c1,..,c6}; bit 6 is the current input c0.
  localparam logic [K-1:0] G0 = 7'o133;
  localparam logic [K-1:0] G1 = 7'o171;
  localparam logic [K-1:0] G2 = 7'o165;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACS,
    S_WR,
    S_TB,
    S_OUT
  } fsm_t;

  // Coded triple {d0,d1,d2} emitted when input b is shifted into state s = {c1..c6}.
  function automatic logic [2:0] branch_sym(input logic b, input logic [SW-1:0] s);
    logic [K-1:0] r;
    r = {b, s};
    return {^(r & G0), ^(r & G1), ^(r & G2)};
  endfunction

  function automatic logic [1:0] hamming3(input logic [2:0] a, input logic [2:0] c);
    logic [2:0] x;
    x = a ^ c;
    return {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]};
  endfunction

endpackage

// File: rtl/survivor_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, registered read data.
// Latency: read data appears the cycle after re is asserted; rdata holds while re is low.
// Backpressure: none; the owner sequences reads and writes.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
module survivor_ram #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 64,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/viterbi_decoder_bs.sv
// Hard-decision serial Viterbi decoder for the K=7 rate-1/3 tail-biting code.
// Latency: 66 cycles per input stage, 2*blk_len traceback cycles, then one bit per accepted handshake.
// Backpressure: sym_ready only in S_LOAD; out_valid/out_bit held stable while out_ready is low.
// Ports: clk, reset (async, active-high); blk_start/blk_len start a block (len_err flags bad length);
//        sym_valid/sym/sym_ready symbol input; out_valid/out_ready/out_bit/out_last decoded stream;
//        busy high whenever a block is in progress.
module viterbi_decoder_bs
  import conv_pkg::*;
#(
  parameter int MAX_LEN = 6144,
  parameter int LEN_W   = 13,
  parameter int PM_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_start,
  input  logic [LEN_W-1:0] blk_len,
  input  logic             sym_valid,
  input  logic [2:0]       sym,
  output logic             sym_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy,
  output logic             len_err
);

  localparam int AW = $clog2(MAX_LEN);

  fsm_t state, state_nx;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] t;          // current trellis stage (ACS and traceback)
  logic [SW-1:0]    n;          // state being updated by the serial ACS
  logic [2:0]       sym_q;
  logic             bank;       // 0: bank A holds current metrics, 1: bank B

  logic [NSTATES-1:0][PM_W-1:0] pm_a;
  logic [NSTATES-1:0][PM_W-1:0] pm_b;

  logic [NSTATES-1:0] dec_word;
  logic [PM_W-1:0]    best_pm;
  logic [SW-1:0]      best_st;

  logic               tb_phase; // 0: read issued, 1: decision word available
  logic [SW-1:0]      tb_st;
  logic [LEN_W-1:0]   oidx;
  logic               ovld;

  logic [NSTATES-1:0] sv_rdata;
  logic               ob_rdata;

  // ---------------------------------------------------------------- control terms
  logic start_ok, start_bad, last_stage, last_bit, out_fire;

  assign start_ok   = blk_start && (blk_len != '0) && (blk_len <= LEN_W'(MAX_LEN));
  assign start_bad  = blk_start && !start_ok;
  assign last_stage = (t == len_q - 1'b1);
  assign last_bit   = (oidx == len_q - 1'b1);
  assign out_fire   = ovld && out_ready;

  // ---------------------------------------------------------------- serial ACS
  // New state n = {b, x}; predecessors differ only in their oldest bit c6.
  logic [SW-1:0]   p0, p1;
  logic            b_in;
  logic [PM_W-1:0] pm_p0, pm_p1, m0, m1, diff, pm_new, bdiff;
  logic [1:0]      bm0, bm1;
  logic            dec, better;

  assign p0     = {n[SW-2:0], 1'b0};
  assign p1     = {n[SW-2:0], 1'b1};
  assign b_in   = n[SW-1];
  assign pm_p0  = bank ? pm_b[p0] : pm_a[p0];
  assign pm_p1  = bank ? pm_b[p1] : pm_a[p1];
  assign bm0    = hamming3(sym_q, branch_sym(b_in, p0));
  assign bm1    = hamming3(sym_q, branch_sym(b_in, p1));
  assign m0     = pm_p0 + PM_W'(bm0);
  assign m1     = pm_p1 + PM_W'(bm1);
  // Metrics are never normalised, so "less than" is the sign of the modular difference.
  assign diff   = m1 - m0;
  assign dec    = diff[PM_W-1];         // ties keep p0
  assign pm_new = dec ? m1 : m0;
  assign bdiff  = pm_new - best_pm;
  assign better = (n == '0) || bdiff[PM_W-1]; // strict: ties keep the lower index

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start_ok) state_nx = S_LOAD;
      S_LOAD: if (sym_valid) state_nx = S_ACS;
      S_ACS:  if (n == SW'(NSTATES - 1)) state_nx = S_WR;
      S_WR:   state_nx = last_stage ? S_TB : S_LOAD;
      S_TB:   if (tb_phase && (t == '0)) state_nx = S_OUT;
      S_OUT:  if (out_fire && last_bit) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      t        <= '0;
      n        <= '0;
      sym_q    <= '0;
      bank     <= 1'b0;
      pm_a     <= '0;
      pm_b     <= '0;
      dec_word <= '0;
      best_pm  <= '0;
      best_st  <= '0;
      tb_phase <= 1'b0;
      tb_st    <= '0;
      oidx     <= '0;
      ovld     <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      len_err <= (state == S_IDLE) && start_bad;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            // Tail-biting: the start state is unknown, so every state starts equal.
            len_q <= blk_len;
            t     <= '0;
            bank  <= 1'b0;
            pm_a  <= '0;
            pm_b  <= '0;
          end
        end
        S_LOAD: begin
          if (sym_valid) begin
            sym_q <= sym;
            n     <= '0;
          end
        end
        S_ACS: begin
          if (bank) pm_a[n] <= pm_new;
          else      pm_b[n] <= pm_new;
          // After 64 shifts bit n of the word holds the decision for state n.
          dec_word <= {dec, dec_word[NSTATES-1:1]};
          n        <= n + 1'b1;
          if (better) begin
            best_pm <= pm_new;
            best_st <= n;
          end
        end
        S_WR: begin
          bank <= ~bank;
          if (last_stage) begin
            tb_phase <= 1'b0;
            tb_st    <= best_st;
          end else begin
            t <= t + 1'b1;
          end
        end
        S_TB: begin
          tb_phase <= ~tb_phase;
          if (tb_phase) begin
            tb_st <= {tb_st[SW-2:0], sv_rdata[tb_st]};
            if (t != '0) begin
              t <= t - 1'b1;
            end else begin
              oidx <= '0;
              ovld <= 1'b0;
            end
          end
        end
        S_OUT: begin
          // The entry cycle prefetches bit 0; valid from the next cycle on.
          ovld <= 1'b1;
          if (out_fire) begin
            if (last_bit) ovld <= 1'b0;
            else          oidx <= oidx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- memories
  logic          sv_we, sv_re, ob_we, ob_re;
  logic [AW-1:0] ob_raddr;

  assign sv_we    = (state == S_WR);
  assign sv_re    = (state == S_TB) && !tb_phase;
  assign ob_we    = (state == S_TB) && tb_phase;
  assign ob_re    = (state == S_OUT);
  // Advance the read address on the handshake so the next bit lands one cycle later;
  // otherwise re-read the same address so out_bit holds during a stall.
  assign ob_raddr = (out_fire && !last_bit) ? AW'(oidx + 1'b1) : AW'(oidx);

  survivor_ram #(.WIDTH(NSTATES), .DEPTH(MAX_LEN)) u_surv (
    .clk   (clk),
    .we    (sv_we),
    .waddr (AW'(t)),
    .wdata (dec_word),
    .re    (sv_re),
    .raddr (AW'(t)),
    .rdata (sv_rdata)
  );

  survivor_ram #(.WIDTH(1), .DEPTH(MAX_LEN)) u_obits (
    .clk   (clk),
    .we    (ob_we),
    .waddr (AW'(t)),
    .wdata (tb_st[SW-1]),
    .re    (ob_re),
    .raddr (ob_raddr),
    .rdata (ob_rdata)
  );

  // ---------------------------------------------------------------- outputs
  assign busy      = (state != S_IDLE);
  assign sym_ready = (state == S_LOAD);
  assign out_valid = ovld;
  assign out_bit   = ovld & ob_rdata;
  assign out_last  = ovld & last_bit;

endmodule

// File: tb/tb_viterbi_decoder_bs.sv
// Directed bench for viterbi_decoder_bs: a table of block cases (length, message kind,
// injected symbol errors, output stalls, busy-time start pokes, expected len_err),
// plus a hand-written mid-block reset sequence.
module tb_viterbi_decoder_bs;

  localparam int MAX_LEN = 6144;
  localparam int LEN_W   = 13;
  localparam int MAXB    = 400;

  logic             clk = 1'b0;
  logic             reset;
  logic             blk_start;
  logic [LEN_W-1:0] blk_len;
  logic             sym_valid;
  logic [2:0]       sym;
  logic             sym_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;
  logic             busy;
  logic             len_err;

  viterbi_decoder_bs #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .PM_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .blk_start (blk_start),
    .blk_len   (blk_len),
    .sym_valid (sym_valid),
    .sym       (sym),
    .sym_ready (sym_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       msg  [MAXB];
  logic [2:0] syms [MAXB];

  typedef struct {
    int len;
    int kind;     // 0: all-zero message, 1: random message
    bit flip;     // flip one symbol bit every 20 stages
    bit stall;    // random 50% out_ready stalls
    bit poke;     // blk_start pulses while busy
    bit exp_err;  // expected len_err response
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference encoder: state s = {c1..c6}, c1 = s[5].
  function automatic logic [2:0] enc(input logic b, input logic [5:0] s);
    return {b ^ s[4] ^ s[3] ^ s[1] ^ s[0],
            b ^ s[5] ^ s[4] ^ s[3] ^ s[0],
            b ^ s[5] ^ s[4] ^ s[2] ^ s[0]};
  endfunction

  task automatic send_sym(input logic [2:0] s, input int idx);
    int n = 0;
    sym       = s;
    sym_valid = 1'b1;
    while (!sym_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("sym_ready_stage%0d", idx), sym_ready, 1);
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic run_case(input int idx);
    vec_t v;
    logic [5:0] s;
    logic [2:0] fl;
    int j, cnt, errs, lasterr, holds, guard;
    bit done, stalled, seen;
    logic pbit;
    v = vt[idx];

    for (int i = 0; i < v.len && i < MAXB; i++)
      msg[i] = (v.kind == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

    blk_len   = LEN_W'(v.len);
    blk_start = 1'b1;
    @(negedge clk);
    blk_start = 1'b0;
    check($sformatf("c%0d_len_err", idx), len_err, v.exp_err);
    check($sformatf("c%0d_busy_start", idx), busy, !v.exp_err);

    if (v.exp_err) begin
      seen = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        seen = seen | sym_ready | busy | len_err;
      end
      check($sformatf("c%0d_stays_idle", idx), seen, 0);
      return;
    end

    // Tail-biting start state holds the last six message bits, newest in c1.
    for (int k = 1; k <= 6; k++) begin
      j = v.len - k;
      while (j < 0) j += v.len;
      s[6-k] = msg[j];
    end
    for (int i = 0; i < v.len; i++) begin
      syms[i] = enc(msg[i], s);
      s = {msg[i], s[5:1]};
      if (v.flip && (i % 20 == 10)) begin
        fl = 3'b001 << ((i / 20) % 3);
        syms[i] = syms[i] ^ fl;
      end
    end

    for (int i = 0; i < v.len; i++) begin
      send_sym(syms[i], i);
      if (v.poke && i == 5) begin
        blk_len   = '0;
        blk_start = 1'b1;
        @(negedge clk);
        blk_start = 1'b0;
        check($sformatf("c%0d_busy_poke_no_err", idx), len_err, 0);
        blk_len   = LEN_W'(3);
        blk_start = 1'b1;
        @(negedge clk);
        blk_start = 1'b0;
        check($sformatf("c%0d_busy_poke_busy", idx), busy, 1);
      end
    end

    cnt = 0; errs = 0; lasterr = 0; holds = 0; guard = 0;
    done = 0; stalled = 0; pbit = 1'b0;
    while (!done && guard < 4 * v.len + 200) begin
      out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled && (!out_valid || out_bit !== pbit)) holds++;
      stalled = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (cnt < v.len && out_bit !== msg[cnt]) errs++;
          if (out_last !== (cnt == v.len - 1)) lasterr++;
          cnt++;
          if (out_last) done = 1;
        end else begin
          stalled = 1;
          pbit    = out_bit;
        end
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    check($sformatf("c%0d_finished", idx), done, 1);
    check($sformatf("c%0d_bit_count", idx), cnt, v.len);
    check($sformatf("c%0d_bit_errors", idx), errs, 0);
    check($sformatf("c%0d_last_flag_errors", idx), lasterr, 0);
    check($sformatf("c%0d_stall_hold_errors", idx), holds, 0);
    check($sformatf("c%0d_busy_fall", idx), busy, 0);
    check($sformatf("c%0d_valid_fall", idx), out_valid, 0);
  endtask

  initial begin
    vt[0] = '{len: 40,   kind: 0, flip: 0, stall: 0, poke: 1, exp_err: 0};
    vt[1] = '{len: 300,  kind: 1, flip: 0, stall: 0, poke: 0, exp_err: 0};
    vt[2] = '{len: 300,  kind: 1, flip: 1, stall: 0, poke: 0, exp_err: 0};
    vt[3] = '{len: 0,    kind: 0, flip: 0, stall: 0, poke: 0, exp_err: 1};
    vt[4] = '{len: 6145, kind: 0, flip: 0, stall: 0, poke: 0, exp_err: 1};
    vt[5] = '{len: 64,   kind: 1, flip: 0, stall: 1, poke: 0, exp_err: 0};
    vt[6] = '{len: 1,    kind: 0, flip: 0, stall: 0, poke: 0, exp_err: 0};
    vt[7] = '{len: 8191, kind: 0, flip: 0, stall: 0, poke: 0, exp_err: 1};

    reset     = 1'b1;
    blk_start = 1'b0;
    blk_len   = '0;
    sym_valid = 1'b0;
    sym       = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_sym_ready", sym_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_len_err", len_err, 0);

    for (int i = 0; i < 8; i++) run_case(i);

    // Abort a block during the ACS of stage 10, then decode a clean block.
    blk_len   = LEN_W'(40);
    blk_start = 1'b1;
    @(negedge clk);
    blk_start = 1'b0;
    for (int i = 0; i <= 10; i++) send_sym(3'b000, i);
    repeat (5) @(negedge clk);
    check("abort_in_acs_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_sym_ready", sym_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_last", out_last, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_case(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
